// File: rtl/rv_sdram_bridge.sv
// Bridges the softcore's 32-bit valid/ready bus onto the arbiter's 16-bit toggle-handshake port,
// issuing one or two half-word requests per access, with a watchdog that forces completion.
module rv_sdram_bridge #(
    parameter int AW      = 23,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          mem_valid,
    input  logic [31:0]   mem_addr,
    input  logic [31:0]   mem_wdata,
    input  logic [3:0]    mem_wstrb,
    output logic          mem_ready,
    output logic [31:0]   mem_rdata,
    output logic [AW-1:0] rv_addr,
    output logic          rv_word,
    output logic [15:0]   rv_din,
    output logic [1:0]    rv_ds,
    output logic          rv_we,
    output logic          rv_req,
    input  logic          rv_req_ack,
    input  logic [15:0]   rv_dout,
    output logic          err
);

    typedef enum logic [2:0] {
        IDLE, REQ_LO, WAIT_LO, CAP_LO, REQ_HI, WAIT_HI, CAP_HI, DONE
    } state_t;

    state_t        state, state_next;
    logic [AW-3:0] addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic [7:0]    wdog;
    logic          ack_match, launch, is_write, hi_needed, lo_skip, timeout_hit;
    logic          in_req, in_wait, hi_sel;
    logic          unused_addr_bits;

    assign ack_match        = (rv_req_ack == rv_req);
    assign launch           = (state == IDLE) && mem_valid && ack_match;
    assign is_write         = |wstrb_q;
    assign hi_needed        = !is_write || (|wstrb_q[3:2]);
    assign lo_skip          = (|mem_wstrb[3:2]) && (mem_wstrb[1:0] == 2'b00);
    assign timeout_hit      = ((wdog + 8'd1) == 8'(TIMEOUT));
    assign unused_addr_bits = ^{mem_addr[31:AW], mem_addr[1:0]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (launch) state_next = lo_skip ? REQ_HI : REQ_LO;
            REQ_LO:  state_next = WAIT_LO;
            WAIT_LO: if (ack_match)        state_next = CAP_LO;
                     else if (timeout_hit) state_next = DONE;
            CAP_LO:  state_next = hi_needed ? REQ_HI : DONE;
            REQ_HI:  state_next = WAIT_HI;
            WAIT_HI: if (ack_match)        state_next = CAP_HI;
                     else if (timeout_hit) state_next = DONE;
            CAP_HI:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_ready = (state == DONE);
        in_req    = (state == REQ_LO) || (state == REQ_HI);
        in_wait   = (state == WAIT_LO) || (state == WAIT_HI);
        hi_sel    = (state == REQ_HI);
    end

    // Arbiter outputs are only touched in REQ states so they stay stable through the handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wdog      <= '0;
            mem_rdata <= '0;
            rv_addr   <= '0;
            rv_word   <= 1'b0;
            rv_din    <= '0;
            rv_ds     <= '0;
            rv_we     <= 1'b0;
            rv_req    <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (launch) begin
                addr_q  <= mem_addr[AW-1:2];
                wdata_q <= mem_wdata;
                wstrb_q <= mem_wstrb;
            end
            if (in_req) begin
                rv_addr <= {addr_q, hi_sel, 1'b0};
                rv_word <= hi_sel;
                rv_din  <= is_write ? (hi_sel ? wdata_q[31:16] : wdata_q[15:0]) : 16'h0000;
                rv_ds   <= is_write ? (hi_sel ? wstrb_q[3:2] : wstrb_q[1:0]) : 2'b11;
                rv_we   <= is_write;
                rv_req  <= ~rv_req;
                wdog    <= 8'd0;
            end
            if (in_wait && !ack_match) begin
                wdog <= wdog + 8'd1;
                if (timeout_hit) begin
                    err       <= 1'b1;
                    mem_rdata <= 32'hFFFF_FFFF;
                end
            end
            // Arbiter read data is only valid in the cycle after the ack match.
            if (state == CAP_LO && !is_write) mem_rdata[15:0]  <= rv_dout;
            if (state == CAP_HI && !is_write) mem_rdata[31:16] <= rv_dout;
        end
    end

endmodule

// File: tb/tb_rv_sdram_bridge.sv
// Self-checking bench for rv_sdram_bridge: a behavioural toggle-handshake arbiter with a half-word
// memory, a word-level reference memory, vector tables, corner sequences and random traffic.
module tb_rv_sdram_bridge;

    localparam int AW = 23;

    logic          clk;
    logic          resetn;
    logic          mem_valid;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          mem_ready;
    logic [31:0]   mem_rdata;
    logic [AW-1:0] rv_addr;
    logic          rv_word;
    logic [15:0]   rv_din;
    logic [1:0]    rv_ds;
    logic          rv_we;
    logic          rv_req;
    logic          rv_req_ack;
    logic [15:0]   rv_dout;
    logic          err;

    rv_sdram_bridge #(.AW(AW), .TIMEOUT(255)) dut (
        .clk(clk), .resetn(resetn),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .rv_addr(rv_addr), .rv_word(rv_word), .rv_din(rv_din), .rv_ds(rv_ds), .rv_we(rv_we),
        .rv_req(rv_req), .rv_req_ack(rv_req_ack), .rv_dout(rv_dout), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic          word;
        logic [15:0]   din;
        logic [1:0]    ds;
        logic          we;
    } arb_req_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        int          exp_reqs;
        int          exp_lat;
    } vec_t;

    int          total_count = 0;
    int          bad_count   = 0;
    int          ready_count = 0;
    arb_req_t    arb_log[$];
    logic [15:0] half_mem[int unsigned];
    logic [31:0] ref_mem[int unsigned];

    logic        ack_r = 1'b0;
    logic [15:0] arb_dout = 16'h0;
    int          arb_lat = 1;
    int          arb_wait = 0;
    bit          hold_ack = 1'b0;
    bit          arb_clear = 1'b0;
    bit          ack_force_en = 1'b0;
    logic        ack_force_val = 1'b0;
    int unsigned arb_key;
    logic [15:0] arb_half;

    assign rv_req_ack = ack_force_en ? ack_force_val : ack_r;
    assign rv_dout    = arb_dout;

    // Arbiter: serves a pending toggle after arb_lat extra looks, then mirrors rv_req onto the ack.
    always @(posedge clk) begin
        #1;
        if (arb_clear) begin
            ack_r    = 1'b0;
            arb_wait = 0;
        end else if ((rv_req != rv_req_ack) && !hold_ack) begin
            if (arb_wait >= arb_lat) begin
                arb_key  = 32'(rv_addr[AW-1:1]);
                arb_half = half_mem.exists(arb_key) ? half_mem[arb_key] : 16'h0000;
                if (rv_we) begin
                    if (rv_ds[0]) arb_half[7:0]  = rv_din[7:0];
                    if (rv_ds[1]) arb_half[15:8] = rv_din[15:8];
                    half_mem[arb_key] = arb_half;
                end else begin
                    arb_dout = arb_half;
                end
                arb_log.push_back('{rv_addr, rv_word, rv_din, rv_ds, rv_we});
                ack_r    = rv_req;
                arb_wait = 0;
            end else begin
                arb_wait++;
            end
        end else begin
            arb_wait = 0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (mem_ready) ready_count++;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: got no finish, required finish before 1000000");
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_count++;
        if (actual !== expected) begin
            bad_count++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_mem_ready"}, 32'(mem_ready), 32'h0);
        checkOutput({tag, "_mem_rdata"}, mem_rdata, 32'h0);
        checkOutput({tag, "_rv_req"},    32'(rv_req), 32'h0);
        checkOutput({tag, "_rv_addr"},   32'(rv_addr), 32'h0);
        checkOutput({tag, "_rv_word"},   32'(rv_word), 32'h0);
        checkOutput({tag, "_rv_din"},    32'(rv_din), 32'h0);
        checkOutput({tag, "_rv_ds"},     32'(rv_ds), 32'h0);
        checkOutput({tag, "_rv_we"},     32'(rv_we), 32'h0);
        checkOutput({tag, "_err"},       32'(err), 32'h0);
    endtask

    // One CPU transaction; lat counts cycles from the launch edge to the cycle mem_ready is high.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s,
                                 input bit drop, output logic [31:0] rd, output int lat, output bit ok);
        arb_log.delete();
        @(negedge clk);
        mem_addr  = a;
        mem_wdata = w;
        mem_wstrb = s;
        mem_valid = 1'b1;
        ok  = 1'b0;
        lat = -1;
        rd  = 32'h0;
        for (int k = 1; k <= 700; k++) begin
            @(negedge clk);
            if (drop && k == 1) mem_valid = 1'b0;
            if (mem_ready) begin
                ok  = 1'b1;
                lat = k - 1;
                rd  = mem_rdata;
                break;
            end
        end
        mem_valid = 1'b0;
    endtask

    vec_t        vecs[10];
    logic [31:0] rd, exp_rd, exp_word, rnd, a, w;
    logic [3:0]  s;
    int          lat, exp_reqs, rc;
    bit          ok, drop;
    int unsigned widx;

    initial begin
        resetn    = 1'b0;
        mem_valid = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_wstrb = 4'h0;
        #3;
        checkResetValues("reset");
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Write/read pairs; writes expect mem_rdata still holding the previous read.
        vecs[0] = '{32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0000, 2, 8};
        vecs[1] = '{32'h0000_0100, 32'h0,         4'b0000, 32'hDEAD_BEEF, 2, 8};
        vecs[2] = '{32'h0000_0100, 32'h1122_3344, 4'b0100, 32'hDEAD_BEEF, 1, 0};
        vecs[3] = '{32'h0000_0100, 32'h0,         4'b0000, 32'hDE22_BEEF, 2, 8};
        vecs[4] = '{32'h0000_0104, 32'hCAFE_0000, 4'b1100, 32'hDE22_BEEF, 1, 0};
        vecs[5] = '{32'h0000_0104, 32'h0,         4'b0000, 32'hCAFE_0000, 2, 8};
        vecs[6] = '{32'h0000_0104, 32'h1234_5678, 4'b0011, 32'hCAFE_0000, 1, 0};
        vecs[7] = '{32'h0000_0104, 32'h0,         4'b0000, 32'hCAFE_5678, 2, 8};
        vecs[8] = '{32'h0000_0104, 32'hAABB_CCDD, 4'b1001, 32'hCAFE_5678, 2, 8};
        vecs[9] = '{32'h0000_0104, 32'h0,         4'b0000, 32'hAAFE_56DD, 2, 8};
        arb_lat = 1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, 1'b0, rd, lat, ok);
            checkOutput($sformatf("vec%0d_ready", i), 32'(ok), 32'h1);
            checkOutput($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            checkOutput($sformatf("vec%0d_reqs", i), 32'(arb_log.size()), 32'(vecs[i].exp_reqs));
            if (vecs[i].exp_lat > 0)
                checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            @(negedge clk);
            checkOutput($sformatf("vec%0d_ready_pulse", i), 32'(mem_ready), 32'h0);
        end

        // Read of a word whose halves come back as 1234 / ABCD.
        half_mem[32'h33000] = 16'h1234;
        half_mem[32'h33001] = 16'hABCD;
        applyStimulus(32'h0006_6000, 32'h0, 4'b0000, 1'b0, rd, lat, ok);
        checkOutput("rd_ready", 32'(ok), 32'h1);
        checkOutput("rd_rdata", rd, 32'hABCD_1234);
        checkOutput("rd_latency", 32'(lat), 32'd8);
        checkOutput("rd_reqs", 32'(arb_log.size()), 32'd2);
        if (arb_log.size() >= 2) begin
            checkOutput("rd_lo_addr", 32'(arb_log[0].addr), 32'h66000);
            checkOutput("rd_lo_word", 32'(arb_log[0].word), 32'h0);
            checkOutput("rd_lo_ds",   32'(arb_log[0].ds), 32'h3);
            checkOutput("rd_lo_we",   32'(arb_log[0].we), 32'h0);
            checkOutput("rd_hi_addr", 32'(arb_log[1].addr), 32'h66002);
            checkOutput("rd_hi_word", 32'(arb_log[1].word), 32'h1);
            checkOutput("rd_hi_ds",   32'(arb_log[1].ds), 32'h3);
            checkOutput("rd_hi_we",   32'(arb_log[1].we), 32'h0);
        end
        @(negedge clk);
        checkOutput("rd_ready_pulse", 32'(mem_ready), 32'h0);

        // Full-word write: low half first, bytes in place.
        applyStimulus(32'h0000_0200, 32'hDEAD_BEEF, 4'b1111, 1'b0, rd, lat, ok);
        checkOutput("wr_ready", 32'(ok), 32'h1);
        checkOutput("wr_reqs", 32'(arb_log.size()), 32'd2);
        if (arb_log.size() >= 2) begin
            checkOutput("wr_lo_din", 32'(arb_log[0].din), 32'hBEEF);
            checkOutput("wr_lo_ds",  32'(arb_log[0].ds), 32'h3);
            checkOutput("wr_lo_we",  32'(arb_log[0].we), 32'h1);
            checkOutput("wr_hi_din", 32'(arb_log[1].din), 32'hDEAD);
            checkOutput("wr_hi_ds",  32'(arb_log[1].ds), 32'h3);
            checkOutput("wr_hi_word", 32'(arb_log[1].word), 32'h1);
        end

        // Single-byte write in the high half: only one request.
        applyStimulus(32'h0000_0200, 32'hDEAD_BEEF, 4'b0100, 1'b0, rd, lat, ok);
        checkOutput("wrb_ready", 32'(ok), 32'h1);
        checkOutput("wrb_reqs", 32'(arb_log.size()), 32'd1);
        if (arb_log.size() >= 1) begin
            checkOutput("wrb_din",  32'(arb_log[0].din), 32'hDEAD);
            checkOutput("wrb_ds",   32'(arb_log[0].ds), 32'h1);
            checkOutput("wrb_word", 32'(arb_log[0].word), 32'h1);
            checkOutput("wrb_addr", 32'(arb_log[0].addr), 32'h202);
        end

        // mem_valid dropped right after launch: transaction still completes exactly once.
        rc = ready_count;
        applyStimulus(32'h0006_6000, 32'h0, 4'b0000, 1'b1, rd, lat, ok);
        checkOutput("drop_ready", 32'(ok), 32'h1);
        checkOutput("drop_rdata", rd, 32'hABCD_1234);
        checkOutput("drop_reqs", 32'(arb_log.size()), 32'd2);
        repeat (10) @(negedge clk);
        checkOutput("drop_pulses", 32'(ready_count - rc), 32'd1);
        checkOutput("drop_no_relaunch", 32'(arb_log.size()), 32'd2);

        // Ack withheld: watchdog aborts with all-ones data and a sticky err.
        hold_ack = 1'b1;
        applyStimulus(32'h0000_0300, 32'h0, 4'b0000, 1'b0, rd, lat, ok);
        checkOutput("to_ready", 32'(ok), 32'h1);
        checkOutput("to_rdata", rd, 32'hFFFF_FFFF);
        checkOutput("to_err", 32'(err), 32'h1);
        hold_ack = 1'b0;
        repeat (4) @(negedge clk);
        applyStimulus(32'h0000_0300, 32'h1234_5678, 4'b1111, 1'b0, rd, lat, ok);
        checkOutput("to_wr_ready", 32'(ok), 32'h1);
        applyStimulus(32'h0000_0300, 32'h0, 4'b0000, 1'b0, rd, lat, ok);
        checkOutput("to_rd_rdata", rd, 32'h1234_5678);
        checkOutput("to_err_sticky", 32'(err), 32'h1);

        // Reset while waiting on the low half, with the arbiter's ack left out of phase.
        arb_log.delete();
        hold_ack = 1'b1;
        @(negedge clk);
        mem_addr  = 32'h0006_6000;
        mem_wstrb = 4'b0000;
        mem_valid = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("rst_in_wait", 32'(rv_req != rv_req_ack), 32'h1);
        resetn        = 1'b0;
        ack_force_en  = 1'b1;
        ack_force_val = 1'b1;
        arb_clear     = 1'b1;
        #1;
        checkResetValues("midrst");
        @(negedge clk);
        resetn = 1'b1;
        rc = ready_count;
        repeat (6) @(negedge clk);
        checkOutput("rst_blocked_req", 32'(rv_req), 32'h0);
        checkOutput("rst_blocked_ready", 32'(ready_count - rc), 32'h0);
        ack_force_en = 1'b0;
        arb_clear    = 1'b0;
        hold_ack     = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (mem_ready) begin
                ok = 1'b1;
                rd = mem_rdata;
                break;
            end
        end
        mem_valid = 1'b0;
        checkOutput("rst_relaunch_ready", 32'(ok), 32'h1);
        checkOutput("rst_relaunch_rdata", rd, 32'hABCD_1234);

        // Random traffic against the word-level reference memory.
        exp_rd = 32'hABCD_1234;
        for (int t = 0; t < 150; t++) begin
            rnd  = $urandom;
            a    = {rnd[31:23], 21'(32'h1000 + $urandom_range(0, 7)), rnd[1:0]};
            w    = $urandom;
            s    = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) s = 4'b0000;
            arb_lat = $urandom_range(1, 4);
            drop    = ($urandom_range(0, 3) == 0);
            applyStimulus(a, w, s, drop, rd, lat, ok);
            widx     = 32'(a[AW-1:2]);
            exp_word = ref_mem.exists(widx) ? ref_mem[widx] : 32'h0;
            if (s == 4'b0000) begin
                exp_rd   = exp_word;
                exp_reqs = 2;
            end else begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) exp_word[8*b +: 8] = w[8*b +: 8];
                ref_mem[widx] = exp_word;
                exp_reqs = ((s[1:0] != 2'b00) ? 1 : 0) + ((s[3:2] != 2'b00) ? 1 : 0);
            end
            checkOutput($sformatf("rnd%0d_ready", t), 32'(ok), 32'h1);
            checkOutput($sformatf("rnd%0d_rdata", t), rd, exp_rd);
            checkOutput($sformatf("rnd%0d_reqs", t), 32'(arb_log.size()), 32'(exp_reqs));
        end

        $display("test done: total=%0d bad=%0d", total_count, bad_count);
        $finish;
    end

endmodule
